// File: rtl/rom_rd_pkg.sv
// Shared types and constants for the dual-port ROM burst reader.
package rom_rd_pkg;

   localparam int ROM_ADDR_W = 3;
   localparam int ROM_WORDS  = 1 << ROM_ADDR_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } rd_state_t;

endpackage

// File: rtl/rom_rd_fifo.sv
// Synchronous FIFO with two write ports (port 0 older) and one read port.
// Entries hold {last, data}; storage is not reset, only pointers and count.
module rom_rd_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr0_en,
   input  logic [WIDTH-1:0] wr0_data,
   input  logic             wr1_en,
   input  logic [WIDTH-1:0] wr1_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic [PW-1:0]    wr1_ptr;
   logic             pop;

   assign empty   = (count == '0);
   assign pop     = rd_en && !empty;
   assign wr1_ptr = wr0_en ? wptr + PW'(1) : wptr;
   assign rd_data = mem[rptr];

   always_ff @(posedge clk) begin
      if (wr0_en) mem[wptr]    <= wr0_data;
      if (wr1_en) mem[wr1_ptr] <= wr1_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         wptr  <= wptr + PW'(wr0_en) + PW'(wr1_en);
         rptr  <= rptr + PW'(pop);
         count <= count + CW'(wr0_en) + CW'(wr1_en) - CW'(pop);
      end
   end

endmodule

// File: rtl/rom_burst_reader.sv
// Burst read sequencer for a dual-port ROM: issues up to two word fetches per
// clock under a FIFO credit limit and streams the words out in order.
module rom_burst_reader
   import rom_rd_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = ROM_ADDR_W,
   parameter int LEN_WIDTH     = 4,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [ADDRESS_WIDTH-1:0] req_addr,
   input  logic [LEN_WIDTH-1:0]     req_len,
   output logic                     rom_en_a,
   output logic [ADDRESS_WIDTH-1:0] rom_addr_a,
   input  logic [DATA_WIDTH-1:0]    rom_dout_a,
   output logic                     rom_en_b,
   output logic [ADDRESS_WIDTH-1:0] rom_addr_b,
   input  logic [DATA_WIDTH-1:0]    rom_dout_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic                     out_last,
   output logic                     busy
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int REM_W = LEN_WIDTH + 1;
   localparam int FRE_W = CNT_W + 1;

   rd_state_t                state, state_nxt;
   logic [ADDRESS_WIDTH-1:0] cur_addr, cur_addr_nxt;
   logic [REM_W-1:0]         rem, rem_nxt;
   logic                     issue_a, issue_b;
   logic                     last_a, last_b;
   logic [1:0]               inflight;
   logic [FRE_W-1:0]         free;

   logic                     vld_a_p1, vld_b_p1;
   logic                     last_a_p1, last_b_p1;

   logic [CNT_W-1:0]         fifo_count;
   logic                     fifo_empty;
   logic [DATA_WIDTH:0]      head;

   // Credits cover words already in the FIFO plus words whose ROM read is in flight.
   assign inflight = {1'b0, vld_a_p1} + {1'b0, vld_b_p1};
   assign free     = FRE_W'(FIFO_DEPTH) - {1'b0, fifo_count} - FRE_W'(inflight);

   always_comb begin
      state_nxt    = state;
      cur_addr_nxt = cur_addr;
      rem_nxt      = rem;
      issue_a      = 1'b0;
      issue_b      = 1'b0;
      last_a       = 1'b0;
      last_b       = 1'b0;
      req_ready    = 1'b0;
      rom_addr_a   = '0;
      rom_addr_b   = '0;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               cur_addr_nxt = req_addr;
               rem_nxt      = {1'b0, req_len} + REM_W'(1);
               state_nxt    = ISSUE;
            end
         end
         ISSUE: begin
            if (rem >= REM_W'(2) && free >= FRE_W'(2)) begin
               issue_a      = 1'b1;
               issue_b      = 1'b1;
               last_b       = (rem == REM_W'(2));
               rom_addr_a   = cur_addr;
               rom_addr_b   = cur_addr + ADDRESS_WIDTH'(1);
               cur_addr_nxt = cur_addr + ADDRESS_WIDTH'(2);
               rem_nxt      = rem - REM_W'(2);
            end else if (rem == REM_W'(1) && free >= FRE_W'(1)) begin
               issue_a      = 1'b1;
               last_a       = 1'b1;
               rom_addr_a   = cur_addr;
               cur_addr_nxt = cur_addr + ADDRESS_WIDTH'(1);
               rem_nxt      = '0;
            end
            if (rem_nxt == '0) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (out_valid && out_ready && out_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign rom_en_a = issue_a;
   assign rom_en_b = issue_b;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cur_addr <= '0;
         rem      <= '0;
      end else begin
         state    <= state_nxt;
         cur_addr <= cur_addr_nxt;
         rem      <= rem_nxt;
      end
   end

   // Stage p1: ROM data valid one cycle after issue; tags follow the read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_a_p1  <= 1'b0;
         vld_b_p1  <= 1'b0;
         last_a_p1 <= 1'b0;
         last_b_p1 <= 1'b0;
      end else begin
         vld_a_p1  <= issue_a;
         vld_b_p1  <= issue_b;
         last_a_p1 <= last_a;
         last_b_p1 <= last_b;
      end
   end

   rom_rd_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr0_en   (vld_a_p1),
      .wr0_data ({last_a_p1, rom_dout_a}),
      .wr1_en   (vld_b_p1),
      .wr1_data ({last_b_p1, rom_dout_b}),
      .rd_en    (out_ready),
      .rd_data  (head),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   // Stale storage is masked so the stream reads zero whenever nothing is valid.
   assign out_valid = !fifo_empty;
   assign out_data  = fifo_empty ? '0 : head[DATA_WIDTH-1:0];
   assign out_last  = !fifo_empty && head[DATA_WIDTH];

endmodule

// File: tb/tb_rom_burst_reader.sv
// Bench for rom_burst_reader: behavioural ROM, scoreboard of expected words.
module tb_rom_burst_reader;
   import rom_rd_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_addr;
   logic [3:0] req_len;
   logic       rom_en_a, rom_en_b;
   logic [2:0] rom_addr_a, rom_addr_b;
   logic [7:0] rom_dout_a, rom_dout_b;
   logic       out_valid, out_ready, out_last, busy;
   logic [7:0] out_data;

   logic [7:0] rom_tbl [8] = '{8'hAA, 8'h55, 8'hFF, 8'hB7, 8'h56, 8'h43, 8'h1F, 8'hE2};
   logic [8:0] sb [$];
   int total = 0;
   int bad   = 0;
   int pop_cnt = 0;
   int issue_cnt = 0;

   always #5 clk = ~clk;

   rom_burst_reader dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_len(req_len),
      .rom_en_a(rom_en_a), .rom_addr_a(rom_addr_a), .rom_dout_a(rom_dout_a),
      .rom_en_b(rom_en_b), .rom_addr_b(rom_addr_b), .rom_dout_b(rom_dout_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .busy(busy)
   );

   always @(posedge clk) begin
      if (rom_en_a) rom_dout_a <= rom_tbl[rom_addr_a];
      if (rom_en_b) rom_dout_b <= rom_tbl[rom_addr_b];
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         issue_cnt += int'(rom_en_a) + int'(rom_en_b);
         if (out_valid && out_ready) begin
            pop_cnt++;
            if (sb.size() == 0) begin
               chk("extra_word", {23'd0, out_last, out_data}, 32'hFFFF_FFFF);
            end else begin
               logic [8:0] e;
               e = sb.pop_front();
               chk("out_data", {24'd0, out_data}, {24'd0, e[7:0]});
               chk("out_last", {31'd0, out_last}, {31'd0, e[8]});
            end
         end
      end
   end

   task automatic check_reset(input string tag);
      chk({tag, "_en_a"},  {31'd0, rom_en_a}, 0);
      chk({tag, "_en_b"},  {31'd0, rom_en_b}, 0);
      chk({tag, "_addr_a"}, {29'd0, rom_addr_a}, 0);
      chk({tag, "_addr_b"}, {29'd0, rom_addr_b}, 0);
      chk({tag, "_ovalid"}, {31'd0, out_valid}, 0);
      chk({tag, "_olast"},  {31'd0, out_last}, 0);
      chk({tag, "_odata"},  {24'd0, out_data}, 0);
      chk({tag, "_busy"},   {31'd0, busy}, 0);
      chk({tag, "_rready"}, {31'd0, req_ready}, 1);
   endtask

   // Returns one #1 after the accepting edge.
   task automatic do_req(input int a, input int l);
      int n = 0;
      while (!req_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk("req_ready_wait", {31'd0, req_ready}, 1);
      req_valid = 1'b1;
      req_addr  = 3'(a);
      req_len   = 4'(l);
      for (int i = 0; i <= l; i++)
         sb.push_back({(i == l), rom_tbl[(a + i) % ROM_WORDS]});
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((busy || sb.size() != 0) && n < 300) begin
         @(posedge clk); #1; n++;
      end
      chk({tag, "_idle"}, {31'd0, busy}, 0);
      chk({tag, "_sb_left"}, sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      int n;
      rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset("rst");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Aligned burst of four: two dual issues, first word after two edges.
      do_req(0, 3);
      chk("b1_e0_en_a", {31'd0, rom_en_a}, 1);
      chk("b1_e0_en_b", {31'd0, rom_en_b}, 1);
      chk("b1_e0_ovld", {31'd0, out_valid}, 0);
      @(posedge clk); #1;
      chk("b1_e1_en_a", {31'd0, rom_en_a}, 1);
      chk("b1_e1_en_b", {31'd0, rom_en_b}, 1);
      chk("b1_e1_ovld", {31'd0, out_valid}, 0);
      @(posedge clk); #1;
      chk("b1_e2_ovld", {31'd0, out_valid}, 1);
      chk("b1_e2_en_a", {31'd0, rom_en_a}, 0);
      wait_idle("b1");

      // Wrapping burst.
      do_req(6, 3);
      chk("b2_addr_a0", {29'd0, rom_addr_a}, 6);
      chk("b2_addr_b0", {29'd0, rom_addr_b}, 7);
      @(posedge clk); #1;
      chk("b2_addr_a1", {29'd0, rom_addr_a}, 0);
      chk("b2_addr_b1", {29'd0, rom_addr_b}, 1);
      wait_idle("b2");

      // Odd length: second issue is port A only.
      do_req(1, 2);
      chk("b3_addr_a0", {29'd0, rom_addr_a}, 1);
      chk("b3_addr_b0", {29'd0, rom_addr_b}, 2);
      @(posedge clk); #1;
      chk("b3_en_a1", {31'd0, rom_en_a}, 1);
      chk("b3_en_b1", {31'd0, rom_en_b}, 0);
      chk("b3_addr_a1", {29'd0, rom_addr_a}, 3);
      wait_idle("b3");

      // Single word; busy falls right after the pop.
      do_req(7, 0);
      chk("b4_en_a", {31'd0, rom_en_a}, 1);
      chk("b4_en_b", {31'd0, rom_en_b}, 0);
      chk("b4_addr_a", {29'd0, rom_addr_a}, 7);
      @(posedge clk); #1;
      chk("b4_e1_ovld", {31'd0, out_valid}, 0);
      @(posedge clk); #1;
      chk("b4_e2_ovld", {31'd0, out_valid}, 1);
      chk("b4_e2_last", {31'd0, out_last}, 1);
      chk("b4_e2_data", {24'd0, out_data}, 32'hE2);
      chk("b4_e2_busy", {31'd0, busy}, 1);
      @(posedge clk); #1;
      chk("b4_e3_busy", {31'd0, busy}, 0);
      wait_idle("b4");

      // Backpressure: credits cap outstanding words at the FIFO depth.
      out_ready = 1'b0;
      base = issue_cnt;
      do_req(0, 7);
      repeat (10) begin
         @(posedge clk); #1;
      end
      chk("b5_issued_le4", {31'd0, (issue_cnt - base) <= 4}, 1);
      chk("b5_issued", issue_cnt - base, 4);
      chk("b5_ovld", {31'd0, out_valid}, 1);
      chk("b5_head", {24'd0, out_data}, 32'hAA);
      chk("b5_busy", {31'd0, busy}, 1);
      out_ready = 1'b1;
      wait_idle("b5");

      // Reset mid-burst drops everything in flight.
      base = pop_cnt;
      do_req(0, 7);
      n = 0;
      while (pop_cnt < base + 3 && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk("b6_popped3", {31'd0, pop_cnt >= base + 3}, 1);
      rst_n = 1'b0;
      #1;
      sb.delete();
      check_reset("midrst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_req(2, 1);
      wait_idle("b6");
      repeat (5) @(posedge clk);
      #1;
      chk("b6_quiet", {31'd0, out_valid}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
